// File: rtl/convolution_controller.sv
// Sequencer for the convolution core: loads FILTER_ORDER coefficients, streams NUM_SAMPLES
// samples, flushes with FILTER_ORDER-1 zeros and pulses done. Optional: CONVOLUTION_CONTROLLER_ABORT_EN.
module convolution_controller #(
    parameter int DATA_SIZE    = 16,
    parameter int COEF_SIZE    = 16,
    parameter int FILTER_ORDER = 8,
    parameter int NUM_SAMPLES  = 40
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            start_in,
`ifdef CONVOLUTION_CONTROLLER_ABORT_EN
    input  logic                            abort_in,
    output logic                            aborted_out,
`endif
    input  logic [COEF_SIZE-1:0]            coef_in,
    input  logic                            coef_valid_in,
    output logic                            coef_ready_out,
    input  logic [DATA_SIZE-1:0]            data_in,
    input  logic                            data_valid_in,
    output logic                            data_ready_out,
    output logic                            coef_we_out,
    output logic [$clog2(FILTER_ORDER):0]   coef_addr_out,
    output logic [COEF_SIZE-1:0]            coef_data_out,
    output logic                            mac_clear_out,
    output logic                            conv_valid_out,
    output logic [DATA_SIZE-1:0]            conv_data_out,
    output logic                            busy_out,
    output logic                            done_out
);

    localparam int CW = $clog2(FILTER_ORDER + 1);
    localparam int SW = $clog2(NUM_SAMPLES + 1);
    localparam int AW = $clog2(FILTER_ORDER) + 1;

    localparam logic [CW-1:0] COEF_LAST   = CW'(FILTER_ORDER - 1);
    localparam logic [CW-1:0] FLUSH_LAST  = (FILTER_ORDER > 1) ? CW'(FILTER_ORDER - 2) : '0;
    localparam logic [SW-1:0] SAMPLE_LAST = SW'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_COEF,
        RUN,
        FLUSH,
        DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [CW-1:0]          coef_cnt_q, coef_cnt_d;
    logic [SW-1:0]          sample_cnt_q, sample_cnt_d;
    logic [CW-1:0]          flush_cnt_q, flush_cnt_d;

    logic                   coef_ready_q, coef_ready_d;
    logic                   data_ready_q, data_ready_d;
    logic                   coef_we_q, coef_we_d;
    logic [AW-1:0]          coef_addr_q, coef_addr_d;
    logic [COEF_SIZE-1:0]   coef_data_q, coef_data_d;
    logic                   mac_clear_q, mac_clear_d;
    logic                   conv_valid_q, conv_valid_d;
    logic [DATA_SIZE-1:0]   conv_data_q, conv_data_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   coef_beat;
    logic                   data_beat;
    logic                   abort;

`ifdef CONVOLUTION_CONTROLLER_ABORT_EN
    logic                   aborted_q, aborted_d;

    assign abort       = abort_in && (state_q != IDLE);
    assign aborted_d   = abort;
    assign aborted_out = aborted_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= aborted_d;
        end
    end
`else
    assign abort = 1'b0;
`endif

    // Ready flops are the only qualifiers; valid never feeds back into ready.
    assign coef_beat = coef_valid_in && coef_ready_q;
    assign data_beat = data_valid_in && data_ready_q;

    always_comb begin
        state_d      = state_q;
        coef_cnt_d   = coef_cnt_q;
        sample_cnt_d = sample_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        coef_we_d    = 1'b0;
        coef_addr_d  = coef_addr_q;
        coef_data_d  = coef_data_q;
        mac_clear_d  = 1'b0;
        conv_valid_d = 1'b0;
        conv_data_d  = conv_data_q;
        done_d       = 1'b0;

        case (state_q)
            IDLE: begin
                coef_cnt_d   = '0;
                sample_cnt_d = '0;
                flush_cnt_d  = '0;
                if (start_in) begin
                    state_d = LOAD_COEF;
                end
            end
            LOAD_COEF: begin
                if (coef_beat) begin
                    coef_we_d   = 1'b1;
                    coef_addr_d = AW'(coef_cnt_q);
                    coef_data_d = coef_in;
                    coef_cnt_d  = coef_cnt_q + CW'(1);
                    if (coef_cnt_q == COEF_LAST) begin
                        mac_clear_d = 1'b1;
                        state_d     = RUN;
                    end
                end
            end
            RUN: begin
                if (data_beat) begin
                    conv_valid_d = 1'b1;
                    conv_data_d  = data_in;
                    sample_cnt_d = sample_cnt_q + SW'(1);
                    if (sample_cnt_q == SAMPLE_LAST) begin
                        state_d = (FILTER_ORDER == 1) ? DONE : FLUSH;
                    end
                end
            end
            FLUSH: begin
                conv_valid_d = 1'b1;
                conv_data_d  = '0;
                flush_cnt_d  = flush_cnt_q + CW'(1);
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d       = 1'b1;
                coef_cnt_d   = '0;
                sample_cnt_d = '0;
                flush_cnt_d  = '0;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // An abort overrides everything decided above, including a beat accepted this cycle.
        if (abort) begin
            state_d      = IDLE;
            coef_cnt_d   = '0;
            sample_cnt_d = '0;
            flush_cnt_d  = '0;
            coef_we_d    = 1'b0;
            mac_clear_d  = 1'b0;
            conv_valid_d = 1'b0;
            done_d       = 1'b0;
        end

        coef_ready_d = (state_d == LOAD_COEF);
        data_ready_d = (state_d == RUN);
        busy_d       = (state_d != IDLE) || done_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            coef_cnt_q   <= '0;
            sample_cnt_q <= '0;
            flush_cnt_q  <= '0;
            coef_ready_q <= 1'b0;
            data_ready_q <= 1'b0;
            coef_we_q    <= 1'b0;
            coef_addr_q  <= '0;
            coef_data_q  <= '0;
            mac_clear_q  <= 1'b0;
            conv_valid_q <= 1'b0;
            conv_data_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            coef_cnt_q   <= coef_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            coef_ready_q <= coef_ready_d;
            data_ready_q <= data_ready_d;
            coef_we_q    <= coef_we_d;
            coef_addr_q  <= coef_addr_d;
            coef_data_q  <= coef_data_d;
            mac_clear_q  <= mac_clear_d;
            conv_valid_q <= conv_valid_d;
            conv_data_q  <= conv_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign coef_ready_out = coef_ready_q;
    assign data_ready_out = data_ready_q;
    assign coef_we_out    = coef_we_q;
    assign coef_addr_out  = coef_addr_q;
    assign coef_data_out  = coef_data_q;
    assign mac_clear_out  = mac_clear_q;
    assign conv_valid_out = conv_valid_q;
    assign conv_data_out  = conv_data_q;
    assign busy_out       = busy_q;
    assign done_out       = done_q;

endmodule

// File: tb/tb_convolution_controller.sv
// Directed bench for convolution_controller: nominal, bursty, restart-ignore, reset, FILTER_ORDER=1
// and (with CONVOLUTION_CONTROLLER_ABORT_EN) abort runs.
module tb_convolution_controller;

    localparam int DW = 16;
    localparam int CWD = 16;
    localparam int FO = 8;
    localparam int NS = 40;
    localparam int AW = $clog2(FO) + 1;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic           start_in = 1'b0;
    logic [CWD-1:0] coef_in = '0;
    logic           coef_valid_in = 1'b0;
    logic           coef_ready_out;
    logic [DW-1:0]  data_in = '0;
    logic           data_valid_in = 1'b0;
    logic           data_ready_out;
    logic           coef_we_out;
    logic [AW-1:0]  coef_addr_out;
    logic [CWD-1:0] coef_data_out;
    logic           mac_clear_out;
    logic           conv_valid_out;
    logic [DW-1:0]  conv_data_out;
    logic           busy_out;
    logic           done_out;
`ifdef CONVOLUTION_CONTROLLER_ABORT_EN
    logic           abort_in = 1'b0;
    logic           aborted_out;
    logic           abort1_in = 1'b0;
    logic           aborted1_out;
`endif

    // second instance: single tap, single sample
    logic           start1 = 1'b0;
    logic [CWD-1:0] coef1_in = '0;
    logic           coef1_valid = 1'b0;
    logic           coef1_ready;
    logic [DW-1:0]  data1_in = '0;
    logic           data1_valid = 1'b0;
    logic           data1_ready;
    logic           coef1_we;
    logic [0:0]     coef1_addr;
    logic [CWD-1:0] coef1_data;
    logic           mac_clear1;
    logic           conv_valid1;
    logic [DW-1:0]  conv_data1;
    logic           busy1;
    logic           done1;

    convolution_controller #(
        .DATA_SIZE(DW), .COEF_SIZE(CWD), .FILTER_ORDER(FO), .NUM_SAMPLES(NS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start_in(start_in),
`ifdef CONVOLUTION_CONTROLLER_ABORT_EN
        .abort_in(abort_in), .aborted_out(aborted_out),
`endif
        .coef_in(coef_in), .coef_valid_in(coef_valid_in), .coef_ready_out(coef_ready_out),
        .data_in(data_in), .data_valid_in(data_valid_in), .data_ready_out(data_ready_out),
        .coef_we_out(coef_we_out), .coef_addr_out(coef_addr_out), .coef_data_out(coef_data_out),
        .mac_clear_out(mac_clear_out), .conv_valid_out(conv_valid_out),
        .conv_data_out(conv_data_out), .busy_out(busy_out), .done_out(done_out)
    );

    convolution_controller #(
        .DATA_SIZE(DW), .COEF_SIZE(CWD), .FILTER_ORDER(1), .NUM_SAMPLES(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .start_in(start1),
`ifdef CONVOLUTION_CONTROLLER_ABORT_EN
        .abort_in(abort1_in), .aborted_out(aborted1_out),
`endif
        .coef_in(coef1_in), .coef_valid_in(coef1_valid), .coef_ready_out(coef1_ready),
        .data_in(data1_in), .data_valid_in(data1_valid), .data_ready_out(data1_ready),
        .coef_we_out(coef1_we), .coef_addr_out(coef1_addr), .coef_data_out(coef1_data),
        .mac_clear_out(mac_clear1), .conv_valid_out(conv_valid1),
        .conv_data_out(conv_data1), .busy_out(busy1), .done_out(done1)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int we_addr[$];
    int we_data[$];
    int we_cyc[$];
    int clr_cyc[$];
    int conv_data[$];
    int conv_cyc[$];
    int done_cyc[$];
    int beat_cyc[$];
    int busy_first = -1;
    int busy_last = -1;
    int aborted_cnt = 0;
    int start_cyc = 0;

    always @(negedge clk) begin
        if (coef_we_out) begin
            we_addr.push_back(int'(coef_addr_out));
            we_data.push_back(int'(coef_data_out));
            we_cyc.push_back(cyc);
        end
        if (mac_clear_out) clr_cyc.push_back(cyc);
        if (conv_valid_out) begin
            conv_data.push_back(int'(conv_data_out));
            conv_cyc.push_back(cyc);
        end
        if (done_out) done_cyc.push_back(cyc);
        if (busy_out) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
`ifdef CONVOLUTION_CONTROLLER_ABORT_EN
        if (aborted_out) aborted_cnt++;
`endif
    end

    function automatic logic [CWD-1:0] coef_val(input int i);
        return CWD'(16'hC000 + i * 7);
    endfunction

    function automatic logic [DW-1:0] samp_val(input int k);
        return DW'(16'h1000 + k * 3 + 1);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log;
        @(negedge clk);
        #1;
        we_addr.delete(); we_data.delete(); we_cyc.delete(); clr_cyc.delete();
        conv_data.delete(); conv_cyc.delete(); done_cyc.delete(); beat_cyc.delete();
        busy_first = -1; busy_last = -1; aborted_cnt = 0;
    endtask

    task automatic pulse_start;
        @(negedge clk);
        start_in = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start_in = 1'b0;
    endtask

    // Called at a negedge; offers a beat whenever ready is high.
    task automatic load_coefs(input int n);
        int k = 0;
        int guard = 0;
        while (k < n && guard < 64) begin
            if (coef_ready_out) begin
                coef_valid_in = 1'b1;
                coef_in = coef_val(k);
                k++;
            end else begin
                coef_valid_in = 1'b0;
            end
            guard++;
            @(negedge clk);
        end
        coef_valid_in = 1'b0;
        if (k < n) check_eq("coef_load_timeout", k, n);
    endtask

    task automatic stream(input int n, input bit bursty, input int start_at);
        int k = 0;
        int guard = 0;
        bit tog = 1'b1;
        while (k < n && guard < 400) begin
            start_in = 1'b0;
            if (data_ready_out) begin
                if (!bursty || tog) begin
                    data_valid_in = 1'b1;
                    data_in = samp_val(k);
                    beat_cyc.push_back(cyc);
                    if (k == start_at) start_in = 1'b1;
                    k++;
                end else begin
                    data_valid_in = 1'b0;
                    data_in = 16'hBEEF;
                end
                tog = !tog;
            end else begin
                data_valid_in = 1'b0;
            end
            guard++;
            @(negedge clk);
        end
        data_valid_in = 1'b0;
        start_in = 1'b0;
        if (k < n) check_eq("data_stream_timeout", k, n);
    endtask

    task automatic wait_idle;
        int g = 0;
        while (busy_out && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy_out) check_eq("busy_timeout", busy_out, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_run(input string name);
        check_eq({name, "_busy_first"}, busy_first, start_cyc + 1);
        check_eq({name, "_we_count"}, we_addr.size(), FO);
        if (we_addr.size() == FO) begin
            for (int i = 0; i < FO; i++) begin
                check_eq($sformatf("%s_we_addr%0d", name, i), we_addr[i], i);
                check_eq($sformatf("%s_we_data%0d", name, i), we_data[i], coef_val(i));
            end
        end
        check_eq({name, "_clear_count"}, clr_cyc.size(), 1);
        if (clr_cyc.size() == 1 && we_cyc.size() == FO)
            check_eq({name, "_clear_with_last_we"}, clr_cyc[0], we_cyc[FO-1]);
        check_eq({name, "_conv_count"}, conv_data.size(), NS + FO - 1);
        if (conv_data.size() == NS + FO - 1 && beat_cyc.size() == NS) begin
            for (int k = 0; k < NS; k++) begin
                check_eq($sformatf("%s_sample%0d", name, k), conv_data[k], samp_val(k));
                check_eq($sformatf("%s_sample_lat%0d", name, k), conv_cyc[k], beat_cyc[k] + 1);
            end
            for (int j = 0; j < FO - 1; j++) begin
                check_eq($sformatf("%s_flush_data%0d", name, j), conv_data[NS+j], 0);
                check_eq($sformatf("%s_flush_cyc%0d", name, j), conv_cyc[NS+j], conv_cyc[NS-1] + 1 + j);
            end
        end
        check_eq({name, "_done_count"}, done_cyc.size(), 1);
        if (done_cyc.size() == 1 && conv_cyc.size() > 0) begin
            check_eq({name, "_done_cyc"}, done_cyc[0], conv_cyc[conv_cyc.size()-1] + 1);
            check_eq({name, "_busy_last"}, busy_last, done_cyc[0]);
        end
    endtask

    task automatic nominal_run(input string name, input bit bursty, input int start_at);
        clear_log();
        data_valid_in = 1'b1;
        data_in = 16'hDEAD;
        pulse_start();
        load_coefs(FO);
        coef_valid_in = 1'b1;
        coef_in = 16'h5A5A;
        stream(NS, bursty, start_at);
        coef_valid_in = 1'b0;
        wait_idle();
        check_run(name);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #12;
        check_eq("rst_busy", busy_out, 0);
        check_eq("rst_coef_ready", coef_ready_out, 0);
        check_eq("rst_data_ready", data_ready_out, 0);
        check_eq("rst_we", coef_we_out, 0);
        check_eq("rst_clear", mac_clear_out, 0);
        check_eq("rst_conv_valid", conv_valid_out, 0);
        check_eq("rst_done", done_out, 0);
        check_eq("rst_addr", coef_addr_out, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        nominal_run("nominal", 1'b0, -1);
        nominal_run("bursty_restart", 1'b1, 20);

        // reset in the middle of RUN
        clear_log();
        pulse_start();
        load_coefs(FO);
        stream(10, 1'b0, -1);
        reset_n = 1'b0;
        #1;
        check_eq("midrst_busy", busy_out, 0);
        check_eq("midrst_data_ready", data_ready_out, 0);
        check_eq("midrst_conv_valid", conv_valid_out, 0);
        check_eq("midrst_conv_data", conv_data_out, 0);
        check_eq("midrst_addr", coef_addr_out, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("midrst_no_done", done_cyc.size(), 0);
        check_eq("midrst_idle_busy", busy_out, 0);
        check_eq("midrst_idle_coef_ready", coef_ready_out, 0);
        nominal_run("after_reset", 1'b0, -1);

        // FILTER_ORDER=1, NUM_SAMPLES=1
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check_eq("fo1_coef_ready", coef1_ready, 1);
        coef1_valid = 1'b1;
        coef1_in = 16'h1234;
        @(negedge clk);
        coef1_valid = 1'b0;
        check_eq("fo1_we", coef1_we, 1);
        check_eq("fo1_addr", coef1_addr, 0);
        check_eq("fo1_coef_data", coef1_data, 16'h1234);
        check_eq("fo1_clear", mac_clear1, 1);
        check_eq("fo1_data_ready", data1_ready, 1);
        check_eq("fo1_coef_ready_low", coef1_ready, 0);
        data1_valid = 1'b1;
        data1_in = 16'h0055;
        @(negedge clk);
        data1_valid = 1'b0;
        check_eq("fo1_conv_valid", conv_valid1, 1);
        check_eq("fo1_conv_data", conv_data1, 16'h0055);
        check_eq("fo1_done_early", done1, 0);
        check_eq("fo1_we_once", coef1_we, 0);
        @(negedge clk);
        check_eq("fo1_done", done1, 1);
        check_eq("fo1_no_flush", conv_valid1, 0);
        check_eq("fo1_busy_at_done", busy1, 1);
        @(negedge clk);
        check_eq("fo1_done_pulse", done1, 0);
        check_eq("fo1_busy_drop", busy1, 0);

`ifdef CONVOLUTION_CONTROLLER_ABORT_EN
        clear_log();
        pulse_start();
        load_coefs(3);
        coef_valid_in = 1'b1;
        coef_in = coef_val(3);
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        coef_valid_in = 1'b0;
        check_eq("abort_aborted", aborted_out, 1);
        check_eq("abort_busy", busy_out, 0);
        check_eq("abort_coef_ready", coef_ready_out, 0);
        check_eq("abort_we", coef_we_out, 0);
        @(negedge clk);
        check_eq("abort_pulse", aborted_out, 0);
        repeat (5) @(negedge clk);
        check_eq("abort_we_count", we_addr.size(), 3);
        check_eq("abort_pulse_count", aborted_cnt, 1);
        check_eq("abort_no_done", done_cyc.size(), 0);
        nominal_run("after_abort", 1'b0, -1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
